regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 88 ++++++++
 tb/tb_regfile_scoreboard.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters (scoreboard).
// Combinational reads with writeback bypass; issue stalls when a destination counter saturates.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic              wb_err
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] rf  [NREG];
  logic [CNT_W-1:0]  cnt [NREG];

  logic            wb_act;
  logic            wb_dec;
  logic            iss_inc;
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic [CNT_W-1:0] cnt_ra1;
  logic [CNT_W-1:0] cnt_ra2;

  assign wb_act    = we3 && (wa3 != '0);
  assign wb_dec    = wb_act && (cnt[wa3] != '0);
  // Ready looks only at the stored count, so a same-cycle writeback cannot unblock a full register.
  assign iss_ready = !((iss_rd != '0) && (cnt[iss_rd] == CNT_MAX));
  assign iss_inc   = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_inc) inc_vec[iss_rd] = 1'b1;
    if (wb_dec)  dec_vec[wa3]    = 1'b1;
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) rd1 = (wb_act && (wa3 == ra1)) ? wd3 : rf[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) rd2 = (wb_act && (wa3 == ra2)) ? wd3 : rf[ra2];
  end

  // Busy reflects the count after this cycle's retiring writeback; new issues are not visible yet.
  assign cnt_ra1 = cnt[ra1] - CNT_W'(wb_dec && (wa3 == ra1));
  assign cnt_ra2 = cnt[ra2] - CNT_W'(wb_dec && (wa3 == ra2));
  assign busy1   = (ra1 != '0) && (cnt_ra1 != '0);
  assign busy2   = (ra2 != '0) && (cnt_ra2 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i]  <= '0;
        cnt[i] <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      if (wb_act) rf[wa3] <= wd3;
      if (wb_act && (cnt[wa3] == '0)) wb_err <= 1'b1;
      for (int i = 0; i < NREG; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs of the same cycle.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, iss_rd, wa3;
  logic [31:0] rd1, rd2, wd3;
  logic        busy1, busy2, iss_valid, iss_ready, we3, wb_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t sb[$];

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s.stale: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
      end else begin
        chk(e.name, "rd1",       rd1,             e.rd1);
        chk(e.name, "rd2",       rd2,             e.rd2);
        chk(e.name, "busy1",     {31'b0, busy1},     {31'b0, e.busy1});
        chk(e.name, "busy2",     {31'b0, busy2},     {31'b0, e.busy2});
        chk(e.name, "iss_ready", {31'b0, iss_ready}, {31'b0, e.rdy});
        chk(e.name, "wb_err",    {31'b0, wb_err},    {31'b0, e.err});
      end
    end
  end

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic iv, input logic [4:0] ird,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                      input logic e_b1, input logic e_b2, input logic e_rdy, input logic e_err);
    exp_t e;
    reset = rst; ra1 = a1; ra2 = a2;
    iss_valid = iv; iss_rd = ird;
    we3 = we; wa3 = wa; wd3 = wd;
    e.cyc = cyc; e.name = nm;
    e.rd1 = e_rd1; e.rd2 = e_rd2;
    e.busy1 = e_b1; e.busy2 = e_b2; e.rdy = e_rdy; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ra1 = '0; ra2 = '0; iss_valid = 1'b0; iss_rd = '0;
    we3 = 1'b0; wa3 = '0; wd3 = '0;
    repeat (2) @(posedge clk);
    #1;
    //    name          rst a1  a2  iv ird we wa  wd             rd1            rd2            b1 b2 rdy err
    step("after_rst",   0,  0,  0,  0, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("iss_r5",      0,  5,  0,  1, 5,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("bypass_r5",   0,  5,  5,  0, 0,  1, 5,  32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 1, 0);
    step("stored_r5",   0,  5,  0,  0, 0,  0, 0,  32'h0,         32'hDEADBEEF,  32'h0,         0, 0, 1, 0);
    step("zero_wr_iss", 0,  0,  5,  1, 0,  1, 0,  32'h1234,      32'h0,         32'hDEADBEEF,  0, 0, 1, 0);
    step("zero_after",  0,  0,  0,  1, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("r7_iss1",     0,  7,  0,  1, 7,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("r7_iss2",     0,  7,  0,  1, 7,  0, 0,  32'h0,         32'h0,         32'h0,         1, 0, 1, 0);
    step("r7_iss3",     0,  7,  0,  1, 7,  0, 0,  32'h0,         32'h0,         32'h0,         1, 0, 1, 0);
    step("r7_full_idle",0,  7,  0,  0, 7,  0, 0,  32'h0,         32'h0,         32'h0,         1, 0, 0, 0);
    step("r7_iss4_wb1", 0,  7,  0,  1, 7,  1, 7,  32'h77,        32'h77,        32'h0,         1, 0, 0, 0);
    step("r7_wb2",      0,  7,  0,  0, 7,  1, 7,  32'h78,        32'h78,        32'h0,         1, 0, 1, 0);
    step("r7_wb3",      0,  7,  0,  0, 7,  1, 7,  32'h79,        32'h79,        32'h0,         0, 0, 1, 0);
    step("r7_drained",  0,  7,  0,  0, 0,  0, 0,  32'h0,         32'h79,        32'h0,         0, 0, 1, 0);
    step("r3_iss",      0,  3,  0,  1, 3,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("r3_set_clr",  0,  3,  0,  1, 3,  1, 3,  32'hA5A5,      32'hA5A5,      32'h0,         0, 0, 1, 0);
    step("r3_after",    0,  3,  0,  0, 0,  0, 0,  32'h0,         32'hA5A5,      32'h0,         1, 0, 1, 0);
    step("r10iss_r3wb", 0,  3, 10,  1, 10, 1, 3,  32'h3333,      32'h3333,      32'h0,         0, 0, 1, 0);
    step("r10_r3_after",0,  3, 10,  0, 0,  0, 0,  32'h0,         32'h3333,      32'h0,         0, 1, 1, 0);
    step("r9_orphan_wb",0,  9, 10,  0, 0,  1, 9,  32'h99,        32'h99,        32'h0,         0, 1, 1, 0);
    step("err_set",     0,  9, 10,  0, 0,  0, 0,  32'h0,         32'h99,        32'h0,         0, 1, 1, 1);
    step("r4_iss1",     0,  9,  4,  1, 4,  0, 0,  32'h0,         32'h99,        32'h0,         0, 0, 1, 1);
    step("r4_iss2",     0,  9,  4,  1, 4,  0, 0,  32'h0,         32'h99,        32'h0,         0, 1, 1, 1);
    step("rst_with_iss",1,  4,  9,  1, 4,  0, 0,  32'h0,         32'h0,         32'h99,        1, 0, 1, 1);
    step("post_rst_r4", 0,  4,  9,  0, 4,  0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    step("post_rst_r10",0, 10,  7,  0, 10, 0, 0,  32'h0,         32'h0,         32'h0,         0, 0, 1, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
